// File: rtl/uart_tx_stream_switch.sv
// Frame-aware 2:1 switch for the board TXD pin: hands TXD between the MCU and the
// debug coprocessor UART streams only at frame boundaries, with a high guard gap.
module uart_tx_stream_switch #(
    parameter int BAUD_PERIOD    = 208,
    parameter int FRAME_BITS     = 10,
    parameter int IDLE_BITS      = 2,
    parameter int GUARD_BITS     = 1,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic tx_cpu,
    input  logic tx_ocd,
    input  logic sel_ocd1_cpu0,
    output logic TXD,
    output logic active_ocd1_cpu0,
    output logic switch_pending,
    output logic force_switch
);

    localparam int FRAME_CYC = FRAME_BITS * BAUD_PERIOD;
    localparam int IDLE_CYC  = IDLE_BITS * BAUD_PERIOD;
    localparam int GUARD_CYC = GUARD_BITS * BAUD_PERIOD;
    localparam int TO_CYC    = TIMEOUT_FRAMES * FRAME_CYC;

    localparam int FW = $clog2(FRAME_CYC) + 1;
    localparam int IW = $clog2(IDLE_CYC) + 1;
    localparam int GW = $clog2(GUARD_CYC) + 1;
    localparam int TW = $clog2(TO_CYC) + 1;

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_DRAIN = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // Index 0 = CPU, index 1 = OCD, matching the encoding of sel_ocd1_cpu0.
    logic [1:0] w_tx;
    logic [1:0] w_in_frame;
    logic [1:0] w_src_idle;

    assign w_tx = {tx_ocd, tx_cpu};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_trk
            logic          r_in_frame;
            logic [FW-1:0] r_frame_cnt;
            logic [IW-1:0] r_idle_cnt;

            always_ff @(posedge clk) begin
                if (sync_reset) begin
                    r_in_frame  <= 1'b0;
                    r_frame_cnt <= '0;
                    r_idle_cnt  <= '0;
                end else begin
                    if (!r_in_frame) begin
                        if (!w_tx[gi]) begin
                            r_in_frame  <= 1'b1;
                            r_frame_cnt <= FW'(FRAME_CYC - 1);
                        end
                    end else if (r_frame_cnt == '0) begin
                        r_in_frame <= 1'b0;
                    end else begin
                        r_frame_cnt <= r_frame_cnt - FW'(1);
                    end

                    if (r_in_frame || !w_tx[gi]) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt != IW'(IDLE_CYC)) begin
                        r_idle_cnt <= r_idle_cnt + IW'(1);
                    end
                end
            end

            assign w_in_frame[gi] = r_in_frame;
            assign w_src_idle[gi] = (r_idle_cnt == IW'(IDLE_CYC));
        end
    endgenerate

    state_t        r_state;
    logic          r_active;
    logic          r_txd;
    logic          r_pending;
    logic          r_force;
    logic [TW-1:0] r_to_cnt;
    logic [GW-1:0] r_guard_cnt;

    logic w_sel_tx;
    logic w_act_idle;
    logic w_req_in_frame;

    assign w_sel_tx       = w_tx[r_active];
    assign w_act_idle     = w_src_idle[r_active];
    assign w_req_in_frame = w_in_frame[sel_ocd1_cpu0];

    // r_pending is updated on every state transition so it tracks DRAIN/GUARD exactly.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state     <= S_SERVE;
            r_active    <= 1'b0;
            r_txd       <= 1'b1;
            r_pending   <= 1'b0;
            r_force     <= 1'b0;
            r_to_cnt    <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_force <= 1'b0;
            r_txd   <= (r_state == S_GUARD) ? 1'b1 : w_sel_tx;

            case (r_state)
                S_SERVE: begin
                    if (sel_ocd1_cpu0 != r_active) begin
                        r_state   <= S_DRAIN;
                        r_pending <= 1'b1;
                        r_to_cnt  <= '0;
                    end
                end

                S_DRAIN: begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                    if (sel_ocd1_cpu0 == r_active) begin
                        r_state   <= S_SERVE;
                        r_pending <= 1'b0;
                    end else if (w_act_idle) begin
                        r_state     <= S_GUARD;
                        r_guard_cnt <= GW'(GUARD_CYC - 1);
                    end else if (r_to_cnt == TW'(TO_CYC - 1)) begin
                        // Outgoing source never went idle: cut it off, even mid-frame.
                        r_force     <= 1'b1;
                        r_state     <= S_GUARD;
                        r_guard_cnt <= GW'(GUARD_CYC - 1);
                    end
                end

                S_GUARD: begin
                    if (r_guard_cnt != '0) begin
                        r_guard_cnt <= r_guard_cnt - GW'(1);
                    end else if (!w_req_in_frame) begin
                        r_active  <= sel_ocd1_cpu0;
                        r_state   <= S_SERVE;
                        r_pending <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_SERVE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign TXD              = r_txd;
    assign active_ocd1_cpu0 = r_active;
    assign switch_pending   = r_pending;
    assign force_switch     = r_force;

endmodule
